// File: rtl/quat_attitude_integrator.sv
// Gyro-rate to attitude integrator: builds a small-angle delta quaternion per sample,
// right-multiplies it into the held attitude and optionally renormalises to first order.
module quat_attitude_integrator #(
  parameter int W        = 16,
  parameter int GW       = 16,
  parameter int DTW      = 32,
  parameter int DT_SHIFT = 20,
  parameter int NORM_EN  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [GW-1:0]  wx,
  input  logic signed [GW-1:0]  wy,
  input  logic signed [GW-1:0]  wz,
  input  logic        [DTW-1:0] dt,
  input  logic                  load_valid,
  input  logic signed [W-1:0]   q0_load,
  input  logic signed [W-1:0]   q1_load,
  input  logic signed [W-1:0]   q2_load,
  input  logic signed [W-1:0]   q3_load,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [W-1:0]   q0,
  output logic signed [W-1:0]   q1,
  output logic signed [W-1:0]   q2,
  output logic signed [W-1:0]   q3,
  output logic                  sat_flag,
  output logic        [15:0]    sample_cnt
);

  localparam int PW = GW + DTW + 1;
  localparam int AW = 2 * W + 2;
  localparam int FW = W + 3;

  localparam logic signed [W-1:0]  ONE      = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0]  NEG_ONE  = {1'b1, {(W-2){1'b0}}, 1'b1};
  localparam logic signed [63:0]   DT_RND   = 64'sd1 <<< (DT_SHIFT - 1);
  localparam logic signed [63:0]   MUL_RND  = 64'sd1 <<< (W - 2);
  localparam logic signed [63:0]   THREE_HALF = 64'sd3 <<< (W - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DELTA  = 3'd1;
  localparam logic [2:0] S_MULT   = 3'd2;
  localparam logic [2:0] S_NSUM   = 3'd3;
  localparam logic [2:0] S_NSCALE = 3'd4;
  localparam logic [2:0] S_OUT    = 3'd5;

  logic [2:0]            state;
  logic signed [GW-1:0]  wx_r, wy_r, wz_r;
  logic        [DTW-1:0] dt_r;
  logic signed [W-1:0]   dq1, dq2, dq3;
  logic signed [W-1:0]   p0, p1, p2, p3;
  logic signed [FW-1:0]  f_r;

  // Upper bit of the result flags that the value had to be clamped to +/-ONE.
  function automatic logic [W:0] clamp(input logic signed [63:0] x);
    if (x > 64'(ONE))
      clamp = {1'b1, ONE};
    else if (x < 64'(NEG_ONE))
      clamp = {1'b1, NEG_ONE};
    else
      clamp = {1'b0, x[W-1:0]};
  endfunction

  function automatic logic signed [AW-1:0] mul(input logic signed [W-1:0] a,
                                               input logic signed [W-1:0] b);
    mul = AW'(a) * AW'(b);
  endfunction

  logic signed [PW-1:0] prod_x, prod_y, prod_z;
  logic [W:0]           dx_c, dy_c, dz_c;
  logic signed [AW-1:0] acc0, acc1, acc2, acc3;
  logic [W:0]           m0_c, m1_c, m2_c, m3_c;
  logic signed [63:0]   sq_sum, n_val, f_val;
  logic [W:0]           s0_c, s1_c, s2_c, s3_c;

  assign prod_x = PW'(wx_r) * PW'($signed({1'b0, dt_r}));
  assign prod_y = PW'(wy_r) * PW'($signed({1'b0, dt_r}));
  assign prod_z = PW'(wz_r) * PW'($signed({1'b0, dt_r}));

  always_comb begin
    dx_c = clamp((64'(prod_x) + DT_RND) >>> DT_SHIFT);
    dy_c = clamp((64'(prod_y) + DT_RND) >>> DT_SHIFT);
    dz_c = clamp((64'(prod_z) + DT_RND) >>> DT_SHIFT);
  end

  // Hamilton product q (x) dq with dq0 fixed at ONE.
  always_comb begin
    acc0 = mul(q0, ONE) - mul(q1, dq1) - mul(q2, dq2) - mul(q3, dq3);
    acc1 = mul(q0, dq1) + mul(q1, ONE) + mul(q2, dq3) - mul(q3, dq2);
    acc2 = mul(q0, dq2) - mul(q1, dq3) + mul(q2, ONE) + mul(q3, dq1);
    acc3 = mul(q0, dq3) + mul(q1, dq2) - mul(q2, dq1) + mul(q3, ONE);
    m0_c = clamp((64'(acc0) + MUL_RND) >>> (W - 1));
    m1_c = clamp((64'(acc1) + MUL_RND) >>> (W - 1));
    m2_c = clamp((64'(acc2) + MUL_RND) >>> (W - 1));
    m3_c = clamp((64'(acc3) + MUL_RND) >>> (W - 1));
  end

  always_comb begin
    sq_sum = 64'(p0) * 64'(p0) + 64'(p1) * 64'(p1)
           + 64'(p2) * 64'(p2) + 64'(p3) * 64'(p3);
    n_val  = sq_sum >>> (W - 1);
    f_val  = (THREE_HALF - n_val) >>> 1;
    s0_c   = clamp((64'(p0) * 64'(f_r) + MUL_RND) >>> (W - 1));
    s1_c   = clamp((64'(p1) * 64'(f_r) + MUL_RND) >>> (W - 1));
    s2_c   = clamp((64'(p2) * 64'(f_r) + MUL_RND) >>> (W - 1));
    s3_c   = clamp((64'(p3) * 64'(f_r) + MUL_RND) >>> (W - 1));
  end

  assign in_ready  = rst && (state == S_IDLE) && !load_valid;
  assign out_valid = (state == S_OUT);

  // q is only written on load or on the edge entering OUT, so partial results never leak.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      wx_r       <= '0;
      wy_r       <= '0;
      wz_r       <= '0;
      dt_r       <= '0;
      dq1        <= '0;
      dq2        <= '0;
      dq3        <= '0;
      p0         <= '0;
      p1         <= '0;
      p2         <= '0;
      p3         <= '0;
      f_r        <= '0;
      q0         <= ONE;
      q1         <= '0;
      q2         <= '0;
      q3         <= '0;
      sat_flag   <= 1'b0;
      sample_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (load_valid) begin
            q0       <= q0_load;
            q1       <= q1_load;
            q2       <= q2_load;
            q3       <= q3_load;
            sat_flag <= 1'b0;
          end else if (in_valid) begin
            wx_r  <= wx;
            wy_r  <= wy;
            wz_r  <= wz;
            dt_r  <= dt;
            state <= S_DELTA;
          end
        end
        S_DELTA: begin
          dq1      <= dx_c[W-1:0];
          dq2      <= dy_c[W-1:0];
          dq3      <= dz_c[W-1:0];
          sat_flag <= sat_flag | dx_c[W] | dy_c[W] | dz_c[W];
          state    <= S_MULT;
        end
        S_MULT: begin
          p0       <= m0_c[W-1:0];
          p1       <= m1_c[W-1:0];
          p2       <= m2_c[W-1:0];
          p3       <= m3_c[W-1:0];
          sat_flag <= sat_flag | m0_c[W] | m1_c[W] | m2_c[W] | m3_c[W];
          if (NORM_EN != 0) begin
            state <= S_NSUM;
          end else begin
            q0         <= m0_c[W-1:0];
            q1         <= m1_c[W-1:0];
            q2         <= m2_c[W-1:0];
            q3         <= m3_c[W-1:0];
            sample_cnt <= sample_cnt + 16'd1;
            state      <= S_OUT;
          end
        end
        S_NSUM: begin
          f_r   <= FW'(f_val);
          state <= S_NSCALE;
        end
        S_NSCALE: begin
          p0         <= s0_c[W-1:0];
          p1         <= s1_c[W-1:0];
          p2         <= s2_c[W-1:0];
          p3         <= s3_c[W-1:0];
          q0         <= s0_c[W-1:0];
          q1         <= s1_c[W-1:0];
          q2         <= s2_c[W-1:0];
          q3         <= s3_c[W-1:0];
          sat_flag   <= sat_flag | s0_c[W] | s1_c[W] | s2_c[W] | s3_c[W];
          sample_cnt <= sample_cnt + 16'd1;
          state      <= S_OUT;
        end
        S_OUT: begin
          if (out_ready)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quat_attitude_integrator.sv
// Directed bench: instance a runs without renormalisation, instance b with it.
module tb_quat_attitude_integrator;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  logic               a_in_valid, a_in_ready, a_load_valid, a_out_valid, a_out_ready, a_sat;
  logic signed [15:0] a_wx, a_wy, a_wz, a_ql0, a_ql1, a_ql2, a_ql3, a_q0, a_q1, a_q2, a_q3;
  logic        [31:0] a_dt;
  logic        [15:0] a_cnt;

  logic               b_in_valid, b_in_ready, b_load_valid, b_out_valid, b_out_ready, b_sat;
  logic signed [15:0] b_wx, b_wy, b_wz, b_ql0, b_ql1, b_ql2, b_ql3, b_q0, b_q1, b_q2, b_q3;
  logic        [31:0] b_dt;
  logic        [15:0] b_cnt;

  quat_attitude_integrator #(.W(16), .GW(16), .DTW(32), .DT_SHIFT(20), .NORM_EN(0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .wx(a_wx), .wy(a_wy), .wz(a_wz), .dt(a_dt), .load_valid(a_load_valid),
    .q0_load(a_ql0), .q1_load(a_ql1), .q2_load(a_ql2), .q3_load(a_ql3),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .q0(a_q0), .q1(a_q1), .q2(a_q2), .q3(a_q3), .sat_flag(a_sat), .sample_cnt(a_cnt)
  );

  quat_attitude_integrator #(.W(16), .GW(16), .DTW(32), .DT_SHIFT(20), .NORM_EN(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .wx(b_wx), .wy(b_wy), .wz(b_wz), .dt(b_dt), .load_valid(b_load_valid),
    .q0_load(b_ql0), .q1_load(b_ql1), .q2_load(b_ql2), .q3_load(b_ql3),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .q0(b_q0), .q1(b_q1), .q2(b_q2), .q3(b_q3), .sat_flag(b_sat), .sample_cnt(b_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    a_in_valid = 0; a_load_valid = 0; a_out_ready = 0;
    a_wx = 0; a_wy = 0; a_wz = 0; a_dt = 0;
    a_ql0 = 0; a_ql1 = 0; a_ql2 = 0; a_ql3 = 0;
    b_in_valid = 0; b_load_valid = 0; b_out_ready = 0;
    b_wx = 0; b_wy = 0; b_wz = 0; b_dt = 0;
    b_ql0 = 0; b_ql1 = 0; b_ql2 = 0; b_ql3 = 0;
    rst = 0;
    tick; tick;
    checks++;
    if ({a_q0, a_q1, a_q2, a_q3} !== {16'sd32767, 16'sd0, 16'sd0, 16'sd0}) begin
      failures++;
      $display("[TB] FAIL reset_q_a got=%h expected=7fff000000000000", {a_q0, a_q1, a_q2, a_q3});
    end
    checks++;
    if ({a_out_valid, a_in_ready, a_sat, a_cnt} !== {3'b000, 16'd0}) begin
      failures++;
      $display("[TB] FAIL reset_flags_a got ov=%b ir=%b sat=%b cnt=%0d expected 0 0 0 0",
               a_out_valid, a_in_ready, a_sat, a_cnt);
    end
    checks++;
    if ({b_q0, b_out_valid, b_in_ready, b_cnt} !== {16'sd32767, 2'b00, 16'd0}) begin
      failures++;
      $display("[TB] FAIL reset_b got q0=%0d ov=%b ir=%b cnt=%0d expected 32767 0 0 0",
               b_q0, b_out_valid, b_in_ready, b_cnt);
    end
    rst = 1;
    tick;
    checks++;
    if ({a_in_ready, b_in_ready} !== 2'b11) begin
      failures++;
      $display("[TB] FAIL release_in_ready got a=%b b=%b expected 1 1", a_in_ready, b_in_ready);
    end
  endtask

  task automatic test_reset_mid_update;
    b_load_valid = 1; b_ql0 = 20000; b_ql1 = 0; b_ql2 = 0; b_ql3 = 0;
    tick;
    b_load_valid = 0;
    b_wx = 1000; b_wy = 0; b_wz = 0; b_dt = 1000; b_in_valid = 1;
    tick;
    b_in_valid = 0;
    tick;
    rst = 0;
    #1;
    checks++;
    if ({b_q0, b_q1, b_q2, b_q3, b_cnt, b_out_valid} !== {16'sd32767, 48'd0, 16'd0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL midreset_q got q=%h cnt=%0d ov=%b expected 7fff000000000000 0 0",
               {b_q0, b_q1, b_q2, b_q3}, b_cnt, b_out_valid);
    end
    tick; tick;
    rst = 1;
    begin
      bit seen = 0;
      for (int i = 0; i < 6; i++) begin
        tick;
        if (b_out_valid) seen = 1;
      end
      checks++;
      if (seen || b_cnt !== 16'd0 || b_q0 !== 16'sd32767) begin
        failures++;
        $display("[TB] FAIL midreset_abort got seen_ov=%b cnt=%0d q0=%0d expected 0 0 32767",
                 seen, b_cnt, b_q0);
      end
    end
  endtask

  task automatic test_basic_update;
    a_wx = 15000; a_wy = 0; a_wz = 0; a_dt = 10000; a_out_ready = 0; a_in_valid = 1;
    tick;
    a_in_valid = 0;
    checks++;
    if (a_in_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_busy got in_ready=%b expected 0", a_in_ready);
    end
    tick;
    checks++;
    if (a_out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_early got out_valid=%b expected 0", a_out_valid);
    end
    tick;
    checks++;
    if (a_out_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL basic_latency got out_valid=%b expected 1", a_out_valid);
    end
    checks++;
    if ({a_q0, a_q1, a_q2, a_q3, a_cnt, a_sat} !== {16'sd32766, 16'sd143, 32'd0, 16'd1, 1'b0}) begin
      failures++;
      $display("[TB] FAIL basic_q got q=(%0d,%0d,%0d,%0d) cnt=%0d sat=%b expected (32766,143,0,0) 1 0",
               a_q0, a_q1, a_q2, a_q3, a_cnt, a_sat);
    end
    a_out_ready = 1;
    tick;
    a_out_ready = 0;
    checks++;
    if ({a_out_valid, a_in_ready} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL basic_handshake got ov=%b ir=%b expected 0 1", a_out_valid, a_in_ready);
    end
  endtask

  task automatic test_saturation;
    a_load_valid = 1; a_ql0 = 32767; a_ql1 = 32767; a_ql2 = 0; a_ql3 = 0;
    tick;
    a_load_valid = 0;
    checks++;
    if ({a_q0, a_q1, a_q2, a_q3} !== {16'sd32767, 16'sd32767, 32'd0}) begin
      failures++;
      $display("[TB] FAIL sat_load got q=%h expected 7fff7fff00000000", {a_q0, a_q1, a_q2, a_q3});
    end
    a_wx = 32767; a_wy = 0; a_wz = 0; a_dt = 32'hFFFF_FFFF; a_in_valid = 1;
    tick;
    a_in_valid = 0;
    tick;
    checks++;
    if (a_sat !== 1'b1) begin
      failures++;
      $display("[TB] FAIL sat_delta got sat_flag=%b expected 1", a_sat);
    end
    tick;
    checks++;
    if ({a_out_valid, a_q0, a_q1, a_q2, a_q3, a_cnt, a_sat} !==
        {1'b1, 16'sd0, 16'sd32767, 32'd0, 16'd2, 1'b1}) begin
      failures++;
      $display("[TB] FAIL sat_result got ov=%b q=(%0d,%0d,%0d,%0d) cnt=%0d sat=%b expected 1 (0,32767,0,0) 2 1",
               a_out_valid, a_q0, a_q1, a_q2, a_q3, a_cnt, a_sat);
    end
    a_out_ready = 1;
    tick;
    a_out_ready = 0;
    a_load_valid = 1; a_ql0 = 32767; a_ql1 = 0; a_ql2 = 0; a_ql3 = 0;
    tick;
    a_load_valid = 0;
    checks++;
    if ({a_sat, a_q0, a_q1} !== {1'b0, 16'sd32767, 16'sd0}) begin
      failures++;
      $display("[TB] FAIL sat_clear got sat=%b q0=%0d q1=%0d expected 0 32767 0", a_sat, a_q0, a_q1);
    end
  endtask

  task automatic test_normalise;
    b_load_valid = 1; b_ql0 = 30000; b_ql1 = 0; b_ql2 = 0; b_ql3 = 0;
    tick;
    b_load_valid = 0;
    b_wx = 0; b_wy = 0; b_wz = 0; b_dt = 1000; b_out_ready = 0; b_in_valid = 1;
    tick;
    b_in_valid = 0;
    tick; tick; tick;
    checks++;
    if (b_out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL norm_early got out_valid=%b expected 0", b_out_valid);
    end
    tick;
    checks++;
    if ({b_out_valid, b_q0, b_q1, b_q2, b_q3, b_cnt, b_sat} !==
        {1'b1, 16'sd32427, 48'd0, 16'd1, 1'b0}) begin
      failures++;
      $display("[TB] FAIL norm_result got ov=%b q=(%0d,%0d,%0d,%0d) cnt=%0d sat=%b expected 1 (32427,0,0,0) 1 0",
               b_out_valid, b_q0, b_q1, b_q2, b_q3, b_cnt, b_sat);
    end
    b_out_ready = 1;
    tick;
    b_out_ready = 0;
  endtask

  task automatic test_back_to_back;
    int bad = 0;
    a_wx = 15000; a_wy = 0; a_wz = 0; a_dt = 10000; a_out_ready = 0; a_in_valid = 1;
    tick;
    a_in_valid = 0;
    tick; tick;
    a_wx = 5000; a_dt = 777; a_in_valid = 1;
    for (int i = 0; i < 10; i++) begin
      tick;
      if ({a_out_valid, a_in_ready, a_q0, a_q1, a_q2, a_q3, a_cnt} !==
          {2'b10, 16'sd32766, 16'sd143, 32'd0, 16'd3}) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("[TB] FAIL backpressure_hold got %0d bad cycles, last ov=%b ir=%b q=(%0d,%0d) cnt=%0d expected 1 0 (32766,143) 3",
               bad, a_out_valid, a_in_ready, a_q0, a_q1, a_cnt);
    end
    a_in_valid = 0; a_out_ready = 1;
    tick;
    a_out_ready = 0;
    checks++;
    if ({a_out_valid, a_in_ready} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL backpressure_release got ov=%b ir=%b expected 0 1", a_out_valid, a_in_ready);
    end
    tick; tick; tick; tick;
    checks++;
    if ({a_out_valid, a_cnt} !== {1'b0, 16'd3}) begin
      failures++;
      $display("[TB] FAIL backpressure_noextra got ov=%b cnt=%0d expected 0 3", a_out_valid, a_cnt);
    end
  endtask

  task automatic test_load_priority;
    bit seen = 0;
    a_load_valid = 1; a_ql0 = 20000; a_ql1 = -1000; a_ql2 = 500; a_ql3 = 7;
    a_wx = 9000; a_dt = 5000; a_in_valid = 1;
    #1;
    checks++;
    if (a_in_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL prio_in_ready got in_ready=%b expected 0", a_in_ready);
    end
    tick;
    a_load_valid = 0; a_in_valid = 0;
    checks++;
    if ({a_q0, a_q1, a_q2, a_q3} !== {16'sd20000, -16'sd1000, 16'sd500, 16'sd7}) begin
      failures++;
      $display("[TB] FAIL prio_load got q=(%0d,%0d,%0d,%0d) expected (20000,-1000,500,7)",
               a_q0, a_q1, a_q2, a_q3);
    end
    for (int i = 0; i < 5; i++) begin
      tick;
      if (a_out_valid) seen = 1;
    end
    checks++;
    if (seen || a_cnt !== 16'd3 || a_q0 !== 16'sd20000) begin
      failures++;
      $display("[TB] FAIL prio_no_sample got seen_ov=%b cnt=%0d q0=%0d expected 0 3 20000",
               seen, a_cnt, a_q0);
    end
  endtask

  initial begin
    test_reset;
    test_reset_mid_update;
    test_basic_update;
    test_saturation;
    test_normalise;
    test_back_to_back;
    test_load_priority;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
